uart_packet_tx: RTL and testbench
=================================

# uart_packet_tx

Client-side framer that sits on one of the two write ports of the UART controller. It accepts a packet descriptor and a stream of payload words from a producer (e.g. systolic-array result drain), requests and holds the controller's write lock, and serializes a checksummed frame into bytes paced by the controller's `write_ready`. It then releases the lock so the other writer can proceed.

## Interface
- `WORD_WIDTH`, 32: payload word width; must be a multiple of 8; `BPW = WORD_WIDTH/8` bytes per word.
- `MAX_WORDS`, 16: maximum payload words per frame.
- `SYNC_BYTE`, 8'hA5: frame start marker.

- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `pkt_valid` in 1: descriptor valid.
- `pkt_ready` out 1: high only in IDLE; descriptor accepted on `pkt_valid && pkt_ready`.
- `pkt_type` in 8: frame type byte.
- `pkt_len` in clog2(MAX_WORDS+1): payload word count.
- `word_data` in WORD_WIDTH: payload word.
- `word_valid` in 1 / `word_ready` out 1: payload handshake.
- `lock_req` out 1: to controller `write_lock_req[n]`.
- `lock_res` in 1: from controller `write_lock_res[n]`.
- `write_ready` in 1: controller `write_ready`.
- `data_out` out 8 / `data_out_valid` out 1: to controller `data_in[n]` / `data_in_valid[n]`.
- `busy` out 1: not IDLE.
- `err` out 1: one-cycle pulse on rejected descriptor.

## Operation
- Frame: SYNC_BYTE, type, len (zero-extended to 8 bits), `len*BPW` payload bytes (each word MSB byte first), checksum.
- Checksum = two's complement of the 8-bit sum of type, len and all payload bytes; the byte-sum of everything after SYNC is 0 mod 256.
- States: IDLE → SYNC → TYPE → LEN → PAYLOAD → CSUM → RELEASE → IDLE.
- Descriptor accept with `pkt_len > MAX_WORDS`: pulse `err`, stay IDLE, no lock request.
- `pkt_len == 0`: LEN → CSUM directly.
- `lock_req` = 1 in SYNC through CSUM, 0 elsewhere.
- A byte is emitted in cycle t iff the state is byte-emitting (SYNC/TYPE/LEN/CSUM, or PAYLOAD with a loaded word) and `lock_res && write_ready`. In that cycle `data_out_valid = 1`, `data_out` = byte, and the byte pointer advances at the clock edge.
- PAYLOAD: `word_ready = 1` when no word is held. On the handshake the word is latched. BPW bytes follow, then the next word is requested. After the final byte of word `len-1`, go to CSUM.
- Producer stall (`word_valid` low): no emission, lock kept.
- Lock lost mid-frame (`lock_res` low while `lock_req` high): stall without advancing; resume on regrant. No byte is dropped or duplicated.
- RELEASE: wait for `lock_res == 0`, then IDLE. The controller only updates the lock while `write_ready` is high.

## Timing
- Reset values: `pkt_ready` 1, `busy` 0, `lock_req` 0, `data_out` 8'h00, `data_out_valid` 0, `word_ready` 0, `err` 0. State is IDLE, counters are 0.
- `data_out_valid`/`data_out` are combinational from registered state plus `lock_res`/`write_ready`; there is no extra latency stage.
- Descriptor accepted at edge 0: `lock_req` is high in cycle 1. SYNC is emitted in the first cycle with `lock_res && write_ready`; the earliest is cycle 2.
- With a continuous grant and `write_ready`, there is one byte per cycle, except one load cycle per payload word (the `word_ready` handshake).
- `data_out` is 0 whenever `data_out_valid` is 0.
- Reset mid-frame: async clear. `lock_req` drops immediately, the frame is truncated, and the partial checksum is discarded.

## Structure
- Package `uart_pkt_pkg`: state enum, default `SYNC_BYTE`, checksum-accumulate function, `BPW` helper.
- Sub-module `uart_word_serializer`: holds one word, exposes `word_ready`, emits bytes MSB-first on an `advance` strobe, and flags the last byte. The FSM, lock handling and checksum stay in the top.

## Test plan
- type 8'h01, len 1, word 32'h11223344, constant grant/ready → valid bytes A5 01 01 11 22 33 44 54. The load cycle gap occurs before byte 11. `lock_req` falls after 54.
- type 8'h7F, len 0 → A5 7F 00 81. `word_ready` is never asserted.
- len 17 with MAX_WORDS=16 → `err` pulses for 1 cycle, `lock_req` stays 0, `pkt_ready` stays 1.
- len 2, `write_ready` toggled 1/0 each cycle and `word_valid` withheld 5 cycles before word 2 → identical byte sequence with correct checksum. No emission while `write_ready` = 0, and the lock is held throughout.
- Grant delayed 10 cycles, then `lock_res` dropped for 3 cycles mid-payload → no `data_out_valid` while `lock_res` = 0, and the sequence resumes at the exact next byte.
- Reset asserted mid-payload → outputs return to reset values asynchronously. The next packet (type 8'h02, len 0) produces A5 02 00 FE.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared states, defaults and checksum helpers for the packet framer.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_TYPE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_RELEASE
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    function automatic int bpw(input int word_width);
        return word_width / 8;
    endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// uart_word_serializer: holds one payload word and shifts it out MSB byte first.
module uart_word_serializer
    import uart_pkt_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  advance,
    output logic                  word_ready,
    output logic                  loaded,
    output logic                  last,
    output logic [7:0]            byte_out
);

    localparam int BPW = bpw(WORD_WIDTH);
    localparam int IW  = BPW > 1 ? $clog2(BPW) : 1;

    logic [WORD_WIDTH-1:0] shreg;
    logic [IW-1:0]         idx;

    assign word_ready = enable && !loaded;
    assign last       = idx == IW'(BPW - 1);
    assign byte_out   = shreg[WORD_WIDTH-1 -: 8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            idx    <= '0;
            loaded <= 1'b0;
        end else if (word_valid && word_ready) begin
            shreg  <= word_data;
            idx    <= '0;
            loaded <= 1'b1;
        end else if (advance && loaded) begin
            shreg  <= shreg << 8;
            idx    <= idx + IW'(1);
            loaded <= !last;
        end
    end

endmodule

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: frames a descriptor plus payload words into a checksummed byte
// stream for one UART controller write port, holding the write lock for the frame.
module uart_packet_tx
    import uart_pkt_pkg::*;
#(
    parameter int         WORD_WIDTH = 32,
    parameter int         MAX_WORDS  = 16,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int         LEN_WIDTH  = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [7:0]            pkt_type,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  lock_req,
    input  logic                  lock_res,
    input  logic                  write_ready,
    output logic [7:0]            data_out,
    output logic                  data_out_valid,
    output logic                  busy,
    output logic                  err
);

    state_t               state, state_n;
    logic [7:0]           type_r;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] wcnt;
    logic [7:0]           sum;
    logic                 err_r;
    logic [7:0]           cur_byte;
    logic                 emit;
    logic                 ser_loaded;
    logic                 ser_last;
    logic [7:0]           ser_byte;

    wire go       = lock_res && write_ready;
    wire len_bad  = pkt_len > LEN_WIDTH'(MAX_WORDS);
    wire accept   = pkt_valid && pkt_ready;
    wire in_pay   = state == ST_PAYLOAD;
    wire last_wrd = wcnt == len_r - LEN_WIDTH'(1);

    uart_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
        .clock      (clock),
        .reset      (reset),
        .enable     (in_pay),
        .word_valid (word_valid),
        .word_data  (word_data),
        .advance    (emit && in_pay),
        .word_ready (word_ready),
        .loaded     (ser_loaded),
        .last       (ser_last),
        .byte_out   (ser_byte)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cur_byte = 8'h00;
        emit     = 1'b0;
        case (state)
            ST_IDLE:    state_n = (pkt_valid && !len_bad) ? ST_SYNC : ST_IDLE;
            ST_SYNC: begin
                cur_byte = SYNC_BYTE;
                emit     = go;
                state_n  = go ? ST_TYPE : ST_SYNC;
            end
            ST_TYPE: begin
                cur_byte = type_r;
                emit     = go;
                state_n  = go ? ST_LEN : ST_TYPE;
            end
            ST_LEN: begin
                cur_byte = 8'(len_r);
                emit     = go;
                state_n  = !go ? ST_LEN : (len_r == '0) ? ST_CSUM : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                cur_byte = ser_byte;
                emit     = go && ser_loaded;
                state_n  = (emit && ser_last && last_wrd) ? ST_CSUM : ST_PAYLOAD;
            end
            ST_CSUM: begin
                cur_byte = ~sum + 8'd1;
                emit     = go;
                state_n  = go ? ST_RELEASE : ST_CSUM;
            end
            ST_RELEASE: state_n = lock_res ? ST_RELEASE : ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Checksum covers type, len and payload; the sync marker is excluded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            type_r <= 8'h00;
            len_r  <= '0;
            wcnt   <= '0;
            sum    <= 8'h00;
            err_r  <= 1'b0;
        end else begin
            err_r <= accept && len_bad;
            if (accept) begin
                type_r <= pkt_type;
                len_r  <= pkt_len;
                wcnt   <= '0;
                sum    <= 8'h00;
            end
            if (emit && (state == ST_TYPE || state == ST_LEN || in_pay))
                sum <= csum_add(sum, cur_byte);
            if (emit && in_pay && ser_last)
                wcnt <= wcnt + LEN_WIDTH'(1);
        end
    end

    assign pkt_ready      = state == ST_IDLE;
    assign busy           = !pkt_ready;
    assign lock_req       = state inside {ST_SYNC, ST_TYPE, ST_LEN, ST_PAYLOAD, ST_CSUM};
    assign data_out_valid = emit;
    assign data_out       = emit ? cur_byte : 8'h00;
    assign err            = err_r;

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: randomized scoreboard bench with a frame-level reference model
// and a simple lock-arbitrating controller model.
module tb_uart_packet_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [7:0]  pkt_type = 8'h00;
    logic [4:0]  pkt_len = 5'd0;
    logic [31:0] word_data = 32'h0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        lock_req;
    logic        lock_res;
    logic        write_ready = 1'b1;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        busy;
    logic        err;

    uart_packet_tx dut (
        .clock          (clock),
        .reset          (reset),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_type       (pkt_type),
        .pkt_len        (pkt_len),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .lock_req       (lock_req),
        .lock_res       (lock_res),
        .write_ready    (write_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy),
        .err            (err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_mode = 0;
    int accept_cyc = 0;
    logic grant_en = 1'b1;
    logic deny = 1'b0;
    logic hs = 1'b0;
    logic wr_seen = 1'b0;
    logic [7:0]  exp_q[$];
    logic [31:0] word_q[$];
    int          stall_q[$];
    int          emit_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    always @(posedge clock) cyc++;

    // Controller model: grants one cycle after request, updates only with write_ready.
    always @(posedge clock or posedge reset) begin
        if (reset) lock_res <= 1'b0;
        else if (write_ready || deny) lock_res <= lock_req && grant_en && !deny;
    end

    always @(posedge clock) begin
        #1;
        case (wr_mode)
            0:       write_ready = 1'b1;
            1:       write_ready = ~write_ready;
            default: write_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Producer: offers queued words, withholding each for its stall count while asked.
    always @(negedge clock) hs = word_valid && word_ready;

    always @(posedge clock) begin
        #1;
        if (hs && word_q.size() > 0) begin
            void'(word_q.pop_front());
            void'(stall_q.pop_front());
        end
        hs = 1'b0;
        if (word_q.size() > 0) begin
            word_valid = stall_q[0] == 0;
            word_data  = word_q[0];
            if (!word_valid && word_ready) stall_q[0] = stall_q[0] - 1;
        end else begin
            word_valid = 1'b0;
        end
    end

    // Monitor: every emitted byte is popped from the scoreboard and compared.
    always @(negedge clock) begin
        if (!reset) begin
            if (word_ready) wr_seen = 1'b1;
            if (busy && exp_q.size() > 0) check("lock_held", lock_req, 1);
            if (data_out_valid) begin
                emit_cyc.push_back(cyc);
                check("emit_allowed", {lock_req, lock_res, write_ready}, 3'b111);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", data_out, 32'hFFFF_FFFF);
                end else begin
                    check("byte", data_out, exp_q.pop_front());
                end
            end else begin
                check("idle_data_zero", data_out, 0);
            end
        end
    end

    task automatic issue(input logic [7:0] t, input int len, input int stall_at, input int stall_n);
        int sum;
        logic [31:0] w;
        if (len <= 16) begin
            sum = t + len;
            exp_q.push_back(8'hA5);
            exp_q.push_back(t);
            exp_q.push_back(8'(len));
            for (int i = 0; i < len; i++) begin
                w = $urandom;
                word_q.push_back(w);
                stall_q.push_back(i == stall_at ? stall_n : 0);
                for (int b = 3; b >= 0; b--) begin
                    exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
                    sum += int'((w >> (8 * b)) & 32'hFF);
                end
            end
            exp_q.push_back(8'((256 - (sum % 256)) % 256));
        end
        @(posedge clock);
        #1;
        pkt_valid = 1'b1;
        pkt_type  = t;
        pkt_len   = 5'(len);
        @(posedge clock);
        #1;
        pkt_valid  = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            #1;
            if (!busy && exp_q.size() == 0) return;
        end
        timeout(name);
        exp_q.delete();
    endtask

    task automatic wait_exp(input string name, input int n);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock);
            #1;
            if (exp_q.size() <= n) return;
        end
        timeout(name);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_pkt_ready"}, pkt_ready, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_lock_req"}, lock_req, 0);
        check({name, "_data_out"}, data_out, 0);
        check({name, "_dov"}, data_out_valid, 0);
        check({name, "_word_ready"}, word_ready, 0);
        check({name, "_err"}, err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Single word, constant grant: check cycle placement of every byte.
        emit_cyc.delete();
        issue(8'h01, 1, -1, 0);
        check("t1_lock_req_cycle1", lock_req, 1);
        begin : t1_wait
            for (int i = 0; i < 100; i++) begin
                @(posedge clock);
                #1;
                if (exp_q.size() == 0) begin
                    check("t1_lock_fall", lock_req, 0);
                    disable t1_wait;
                end
            end
            timeout("t1_frame");
        end
        wait_done("t1_done");
        check("t1_nbytes", emit_cyc.size(), 8);
        if (emit_cyc.size() == 8) begin
            check("t1_first_cycle", emit_cyc[0], accept_cyc + 1);
            check("t1_load_gap", emit_cyc[3] - emit_cyc[2], 2);
            check("t1_span", emit_cyc[7] - emit_cyc[0], 8);
        end

        // Zero-length frame never requests a word.
        wr_seen = 1'b0;
        issue(8'h7F, 0, -1, 0);
        wait_done("t2_done");
        check("t2_no_word_ready", wr_seen, 0);

        // Oversized length is rejected with a one-cycle error pulse.
        issue(8'h10, 17, -1, 0);
        check("t3_err", err, 1);
        check("t3_lock_req", lock_req, 0);
        check("t3_pkt_ready", pkt_ready, 1);
        @(posedge clock);
        #1;
        check("t3_err_drop", err, 0);
        check("t3_lock_req2", lock_req, 0);
        check("t3_pkt_ready2", pkt_ready, 1);

        // Toggling write_ready plus a producer stall before word 2.
        wr_mode = 1;
        issue(8'h5A, 2, 1, 5);
        wait_done("t4_done");
        wr_mode = 0;

        // Delayed grant, then lock withdrawn mid-payload.
        grant_en = 1'b0;
        issue(8'hC3, 3, -1, 0);
        repeat (10) @(posedge clock);
        #1;
        check("t5_no_emit_before_grant", exp_q.size(), 16);
        grant_en = 1'b1;
        wait_exp("t5_mid", 10);
        deny = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        deny = 1'b0;
        wait_done("t5_done");

        // Randomized frames under random write_ready and producer stalls.
        wr_mode = 2;
        for (int k = 0; k < 8; k++) begin
            int len;
            len = $urandom_range(0, 16);
            issue(8'($urandom), len, len > 0 ? $urandom_range(0, len - 1) : -1, $urandom_range(0, 4));
            wait_done("rand_done");
        end
        wr_mode = 0;

        // Asynchronous reset mid-payload, then a clean short frame.
        issue(8'h33, 4, -1, 0);
        wait_exp("t6_mid", 10);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6_async");
        repeat (2) @(posedge clock);
        #1;
        exp_q.delete();
        word_q.delete();
        stall_q.delete();
        word_valid = 1'b0;
        reset = 1'b0;
        issue(8'h02, 0, -1, 0);
        wait_done("t6_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
